// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan multiplexer.
package sseg_pkg;
  typedef enum logic {ST_BLANK, ST_ON} scan_state_t;

  localparam logic [7:0] SSEG_OFF = 8'hFF;

  // $clog2 that never yields a zero-width vector
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction
endpackage

// File: rtl/sseg_dwell_counter.sv
// Modulo dwell counter: counts 0..term and flags the last count; the terminal
// value is loaded each cycle so one instance times both BLANK and ON periods.
module sseg_dwell_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] term,
  output logic         last
);
  logic [W-1:0] cnt;

  assign last = (cnt == term);

  always_ff @(posedge clk) begin
    if (!reset)     cnt <= '0;
    else if (last)  cnt <= '0;
    else            cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/sseg_scan_mux.sv
// Frame-latched, blank-gapped scan driver for a common-anode 7-seg display.
// Define SSEG_DIM_EN to add the dim[3:0] PWM brightness input.
module sseg_scan_mux
  import sseg_pkg::*;
#(
  parameter int N         = 8,
  parameter int SCAN_CNT  = 50000,
  parameter int BLANK_CNT = 500
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [8*N-1:0] in_pat,
  input  logic [N-1:0]   en_mask,
`ifdef SSEG_DIM_EN
  input  logic [3:0]     dim,
`endif
  output logic [N-1:0]   an,
  output logic [7:0]     sseg,
  output logic           frame_tick
);
  localparam int MAXC = (SCAN_CNT > BLANK_CNT) ? SCAN_CNT : BLANK_CNT;
  localparam int CW   = clog2_min1(MAXC);
  localparam int IW   = clog2_min1(N);
  localparam logic [CW-1:0] SCAN_TERM  = CW'(SCAN_CNT - 1);
  localparam logic [CW-1:0] BLANK_TERM = CW'(BLANK_CNT - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N - 1);

  scan_state_t          state, state_d;
  logic [IW-1:0]        idx, idx_d;
  logic [N-1:0][7:0]    pat_q, pat_d;
  logic [N-1:0]         mask_q, mask_d;
  logic [CW-1:0]        term;
  logic                 last, go_on, wrap, lit;
  logic [N-1:0]         an_d;
  logic [7:0]           sseg_d;

  assign term = (state == ST_ON) ? SCAN_TERM : BLANK_TERM;

  sseg_dwell_counter #(.W(CW)) u_dwell (
    .clk   (clk),
    .reset (reset),
    .term  (term),
    .last  (last)
  );

  // Patterns are only sampled when the scan wraps to digit 0, so a CPU write
  // mid-frame cannot produce a frame mixing old and new digits.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    pat_d   = pat_q;
    mask_d  = mask_q;
    go_on   = 1'b0;
    wrap    = 1'b0;
    case (state)
      ST_BLANK: if (last) begin
        go_on   = 1'b1;
        state_d = ST_ON;
        if (idx == IDX_LAST) begin
          idx_d  = '0;
          wrap   = 1'b1;
          pat_d  = in_pat;
          mask_d = en_mask;
        end else begin
          idx_d  = idx + 1'b1;
        end
      end
      ST_ON: if (last) state_d = ST_BLANK;
    endcase
  end

`ifdef SSEG_DIM_EN
  logic [3:0] pwm, pwm_d;

  assign pwm_d = go_on ? 4'd0 : pwm + 4'd1;
  assign lit   = (pwm_d <= dim);

  always_ff @(posedge clk) begin
    if (!reset) pwm <= '0;
    else        pwm <= pwm_d;
  end
`else
  assign lit = 1'b1;
`endif

  // Outputs are decoded from next-state so the latch edge already shows new data
  always_comb begin
    an_d   = '1;
    sseg_d = SSEG_OFF;
    if (state_d == ST_ON && lit && mask_d[idx_d]) begin
      an_d[idx_d] = 1'b0;
      sseg_d      = ~pat_d[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_BLANK;
      idx        <= IDX_LAST;
      pat_q      <= '0;
      mask_q     <= '0;
      an         <= '1;
      sseg       <= SSEG_OFF;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      pat_q      <= pat_d;
      mask_q     <= mask_d;
      an         <= an_d;
      sseg       <= sseg_d;
      frame_tick <= wrap;
    end
  end
endmodule

// File: tb/tb_sseg_scan_mux.sv
// Directed + randomized bench for sseg_scan_mux (N=4, SCAN_CNT=4, BLANK_CNT=2)
// against a time-based reference model of the scan schedule.
module tb_sseg_scan_mux;
  localparam int N     = 4;
  localparam int SCAN  = 4;
  localparam int BLANK = 2;
  localparam int DIG   = SCAN + BLANK;
  localparam int FRAME = N * DIG;

  logic          clk;
  logic          reset;
  logic [8*N-1:0] in_pat;
  logic [N-1:0]  en_mask;
  logic [N-1:0]  an;
  logic [7:0]    sseg;
  logic          frame_tick;
`ifdef SSEG_DIM_EN
  logic [3:0]    dim = 4'hF;
`endif

  int checks = 0;
  int errors = 0;
  int t = 0;
  int ft_cnt = 0;
  int prev_ft = -1;
  logic [8*N-1:0] lat_pat = '0;
  logic [N-1:0]   lat_mask = '0;

  sseg_scan_mux #(.N(N), .SCAN_CNT(SCAN), .BLANK_CNT(BLANK)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_pat     (in_pat),
    .en_mask    (en_mask),
`ifdef SSEG_DIM_EN
    .dim        (dim),
`endif
    .an         (an),
    .sseg       (sseg),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s t=%0d got %h want %h", tag, t, obs, exp_v);
    end
  endtask

  // One clock edge; model derives expected outputs from edges since reset release.
  task automatic tick();
    logic           rst_edge;
    logic [8*N-1:0] cur_pat;
    logic [N-1:0]   cur_mask;
    logic [N-1:0]   ea;
    logic [7:0]     es;
    logic           ef;
    int u, d, w;
    rst_edge = ~reset;
    cur_pat  = in_pat;
    cur_mask = en_mask;
    @(posedge clk);
    #1;
    ea = '1; es = 8'hFF; ef = 1'b0;
    if (rst_edge) begin
      t = 0; lat_pat = '0; lat_mask = '0; prev_ft = -1;
    end else begin
      t++;
      if (t >= BLANK) begin
        u = t - BLANK;
        if (u % FRAME == 0) begin
          ef = 1'b1; lat_pat = cur_pat; lat_mask = cur_mask;
        end
        d = (u / DIG) % N;
        w = u % DIG;
        if (w < SCAN && lat_mask[d]) begin
          ea[d] = 1'b0;
          es    = ~lat_pat[d*8 +: 8];
        end
      end
    end
    chk("an", 32'(an), 32'(ea));
    chk("sseg", 32'(sseg), 32'(es));
    chk("frame_tick", 32'(frame_tick), 32'(ef));
    if (!rst_edge && frame_tick === 1'b1) begin
      ft_cnt++;
      if (prev_ft >= 0) chk("ft_gap", 32'(t - prev_ft), 32'(FRAME));
      prev_ft = t;
    end
  endtask

  initial begin
    reset = 1'b0; in_pat = 32'h3F065B4F; en_mask = 4'hF;
    repeat (3) tick();
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_sseg", 32'(sseg), 32'hFF);

    // Scenario 1: first frame after release
    reset = 1'b1;
    repeat (2) tick();
    chk("first_ft", 32'(frame_tick), 32'h1);
    chk("d0_an", 32'(an), 32'hE);
    chk("d0_sseg", 32'(sseg), 32'hB0);
    repeat (4) tick();
    chk("gap_an", 32'(an), 32'hF);
    repeat (2) tick();
    chk("d1_an", 32'(an), 32'hD);
    chk("d1_sseg", 32'(sseg), 32'hA4);

    // Scenario 2: mid-frame write must not tear the frame
    repeat (6) tick();
    chk("d2_sseg", 32'(sseg), 32'hF9);
    in_pat = 32'h0;
    repeat (6) tick();
    chk("d3_sseg_old", 32'(sseg), 32'hC0);
    repeat (6) tick();
    chk("new_ft", 32'(frame_tick), 32'h1);
    chk("new_sseg", 32'(sseg), 32'hFF);
    chk("new_an", 32'(an), 32'hE);

    // Scenario 3: disabled digits keep their slot
    in_pat = 32'h3F065B4F; en_mask = 4'b0101;
    repeat (2 * FRAME) tick();

    // Randomized patterns and masks written at arbitrary cycles
    repeat (8 * FRAME) begin
      if ($urandom_range(0, 3) == 0) begin
        in_pat  = $urandom;
        en_mask = 4'($urandom_range(0, 15));
      end
      tick();
    end

    // Scenario 4: reset pulse in the middle of an ON window
    for (int i = 0; i < 2 * DIG && ((t - BLANK) % DIG) != 1; i++) tick();
    chk("mid_on_reached", 32'((t - BLANK) % DIG), 32'd1);
    reset = 1'b0;
    tick();
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_sseg", 32'(sseg), 32'hFF);
    chk("mid_rst_ft", 32'(frame_tick), 32'h0);
    reset = 1'b1; in_pat = 32'h3F065B4F; en_mask = 4'hF;
    repeat (2) tick();
    chk("rerun_ft", 32'(frame_tick), 32'h1);
    chk("rerun_an", 32'(an), 32'hE);
    chk("rerun_sseg", 32'(sseg), 32'hB0);

    // Scenario 5: 240 cycles from a clean release give exactly 10 ticks
    reset = 1'b0;
    tick();
    reset = 1'b1; ft_cnt = 0;
    repeat (240) tick();
    chk("ft_count_240", 32'(ft_cnt), 32'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
